// File: rtl/div_pkg.sv
// Shared constants for the iterative restoring divider: operand width,
// counter phases and the divide-by-zero quotient.
package div_pkg;

    localparam int DIV_W = 32;

    // Counter phases: LOAD latches operands, 1..DIV_W iterate, DONE holds the result.
    localparam int LOAD  = 0;
    localparam int DONE  = DIV_W + 1;
    localparam int CNT_W = $clog2(DIV_W + 2);

    localparam logic [DIV_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// run/stall handshake and operand/result bus between the execute stage and the divider.
interface seq_divider_if #(
    parameter int W = 32
);

    logic         run;
    logic         u;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         stall;
    logic [W-1:0] quot;
    logic [W-1:0] rem;

    modport master (
        output run, u, x, y,
        input  stall, quot, rem
    );

    modport slave (
        input  run, u, x, y,
        output stall, quot, rem
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference when it is non-negative.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   r,
    input  logic         qmsb,
    input  logic [W-1:0] d,
    output logic [W:0]   r_next,
    output logic         qbit
);

    // r stays below d, so {r, qmsb} fits in W+1 bits and the top bit of diff is its sign.
    logic signed [W+1:0] diff;

    always_comb begin
        diff   = $signed({r, qmsb}) - $signed({2'b00, d});
        qbit   = ~diff[W+1];
        r_next = qbit ? diff[W:0] : {r[W-1:0], qmsb};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative one-bit-per-cycle restoring divider with unsigned and floor
// (signed dividend) modes, held in execute through the run/stall handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    logic [CNT_W-1:0] s;
    logic [W:0]       r;
    logic [W-1:0]     q;
    logic [W-1:0]     d;
    logic [W-1:0]     x_held;
    logic             neg;
    logic             zero;

    logic [W:0]       r_step;
    logic             q_bit;
    logic             load;
    logic             iter;
    logic             neg_in;
    logic [W-1:0]     quot_c;
    logic [W-1:0]     rem_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(DONE)) ? v : v + 1'b1;
    endfunction

    assign load   = bus.run && (s == CNT_W'(LOAD));
    assign iter   = bus.run && (s != CNT_W'(LOAD)) && (s != CNT_W'(DONE));
    assign neg_in = bus.u & bus.x[W-1];

    div_step #(.W(W)) u_step (
        .r      (r),
        .qmsb   (q[W-1]),
        .d      (d),
        .r_next (r_step),
        .qbit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            s      <= '0;
            r      <= '0;
            q      <= '0;
            d      <= '0;
            x_held <= '0;
            neg    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            s <= bus.run ? sat_inc(s) : '0;
            if (load) begin
                // Magnitude of a negative dividend; 0x80..0 maps onto 2^(W-1) unchanged.
                q      <= neg_in ? -bus.x : bus.x;
                d      <= bus.y;
                r      <= '0;
                x_held <= bus.x;
                neg    <= neg_in;
                zero   <= (bus.y == '0);
            end else if (iter) begin
                r <= r_step;
                q <= {q[W-2:0], q_bit};
            end
        end
    end

    // Floor fix-up: a non-zero remainder pulls the negated quotient down by one.
    always_comb begin
        quot_c = q;
        rem_c  = r[W-1:0];
        if (zero) begin
            quot_c = DIV0_QUOT;
            rem_c  = x_held;
        end else if (neg) begin
            if (r[W-1:0] == '0) begin
                quot_c = -q;
                rem_c  = '0;
            end else begin
                quot_c = ~q;
                rem_c  = d - r[W-1:0];
            end
        end
    end

    assign bus.quot  = quot_c;
    assign bus.rem   = rem_c;
    assign bus.stall = bus.run && (s != CNT_W'(DONE));

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, hand-written handshake
// corner cases and random operands against a floor-division reference model.
module tb_seq_divider;

    import div_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    seq_divider_if #(.W(W)) bus ();

    seq_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        u;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Reference: y==0 special case, otherwise floor division with 64-bit integers.
    function automatic void ref_div(input logic u, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q, output logic [31:0] r);
        longint xs, ys, qq, rr;
        if (y == 0) begin
            q = '1;
            r = x;
            return;
        end
        ys = longint'({32'b0, y});
        xs = u ? longint'($signed(x)) : longint'({32'b0, x});
        qq = xs / ys;
        rr = xs - qq * ys;
        if (rr < 0) begin
            qq = qq - 1;
            rr = rr + ys;
        end
        q = qq[31:0];
        r = rr[31:0];
    endfunction

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.stall && cycles < 200) begin
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    // Starts an operation one step after a rising edge; run stays high on return.
    task automatic do_op(input logic u, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r, output int cycles);
        @(posedge clk);
        #1;
        bus.run = 1'b1;
        bus.u   = u;
        bus.x   = x;
        bus.y   = y;
        #1;
        wait_done(cycles);
        q = bus.quot;
        r = bus.rem;
    endtask

    task automatic end_op();
        bus.run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q, r, eq, er, hold_q, hold_r;
        int cycles, stall_seen, change_seen;

        vecs[0] = '{1'b0, 32'd100,        32'd7, 32'd14,        32'd2};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2, 32'hFFFFFFFC,  32'd1};
        vecs[2] = '{1'b1, 32'hFFFFFFFA,   32'd2, 32'hFFFFFFFD,  32'd0};
        vecs[3] = '{1'b1, 32'h80000000,   32'd1, 32'h80000000,  32'd0};
        vecs[4] = '{1'b1, 32'h80000000,   32'd3, 32'hD5555555,  32'd1};
        vecs[5] = '{1'b0, 32'h80000000,   32'd3, 32'h2AAAAAAA,  32'd2};
        vecs[6] = '{1'b0, 32'h12345678,   32'd0, 32'hFFFFFFFF,  32'h12345678};
        vecs[7] = '{1'b1, 32'hFFFFFFFB,   32'd0, 32'hFFFFFFFF,  32'hFFFFFFFB};
        vecs[8] = '{1'b1, 32'hFFFFFFFB,   32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFB};

        bus.run = 1'b0;
        bus.u   = 1'b0;
        bus.x   = '0;
        bus.y   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", {31'b0, bus.stall}, 32'd0);
        check("reset_quot", bus.quot, 32'd0);
        check("reset_rem", bus.rem, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].u, vecs[i].x, vecs[i].y, q, r, cycles);
            check($sformatf("vec%0d_cycles", i), cycles, 32'd33);
            check($sformatf("vec%0d_quot", i), q, vecs[i].eq);
            check($sformatf("vec%0d_rem", i), r, vecs[i].er);
            end_op();
        end

        // Saturation: results and stall hold for 100 cycles with run high.
        do_op(1'b0, 32'd1000, 32'd7, q, r, cycles);
        check("sat_first_cycles", cycles, 32'd33);
        hold_q = q;
        hold_r = r;
        stall_seen  = 0;
        change_seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.stall) stall_seen++;
            if (bus.quot !== hold_q || bus.rem !== hold_r) change_seen++;
        end
        check("sat_stall_cycles", stall_seen, 32'd0);
        check("sat_result_changes", change_seen, 32'd0);
        check("sat_quot", hold_q, 32'd142);
        end_op();
        check("after_fall_quot", bus.quot, 32'd142);
        check("after_fall_rem", bus.rem, 32'd6);
        do_op(1'b0, 32'd1000, 32'd7, q, r, cycles);
        check("sat_restart_cycles", cycles, 32'd33);
        end_op();

        // Reset in the middle of an operation, then restart with run still high.
        @(posedge clk);
        #1;
        bus.run = 1'b1;
        bus.u   = 1'b0;
        bus.x   = 32'd100;
        bus.y   = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_quot", bus.quot, 32'd0);
        check("midrst_rem", bus.rem, 32'd0);
        check("midrst_stall", {31'b0, bus.stall}, 32'd1);
        rst = 1'b1;
        #1;
        wait_done(cycles);
        check("midrst_restart_cycles", cycles, 32'd33);
        check("midrst_restart_quot", bus.quot, 32'd14);
        check("midrst_restart_rem", bus.rem, 32'd2);
        end_op();

        // run dropped part-way through, then a fresh operation.
        @(posedge clk);
        #1;
        bus.run = 1'b1;
        bus.x   = 32'd100;
        bus.y   = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        do_op(1'b0, 32'd9, 32'd4, q, r, cycles);
        check("drop_cycles", cycles, 32'd33);
        check("drop_quot", q, 32'd2);
        check("drop_rem", r, 32'd1);
        end_op();

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic        ru;
            logic [31:0] rx, ry;
            ru = 1'($urandom_range(0, 1));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = 32'($urandom_range(1, 16));
                1:       ry = 32'($urandom_range(0, 65535));
                2:       ry = (i % 10 == 0) ? 32'd0 : $urandom;
                default: ry = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(ru, rx, ry, eq, er);
            do_op(ru, rx, ry, q, r, cycles);
            check($sformatf("rnd%0d_cycles", i), cycles, 32'd33);
            check($sformatf("rnd%0d_quot u=%0d x=%08h y=%08h", i, ru, rx, ry), q, eq);
            check($sformatf("rnd%0d_rem u=%0d x=%08h y=%08h", i, ru, rx, ry), r, er);
            end_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative one-bit-per-cycle restoring divider, the inverse companion to the sequential multiplier in the RISC5 execute stage.
- Computes quotient and remainder of x / y for DIV and MOD.
- Supports unsigned mode and signed-dividend (floor) mode.
- Uses the same run/stall handshake as the multiplier: the CPU holds run high and freezes the pipeline while stall is high.

Parameters:
W, 32, operand/result width; the iteration counter spans 0..W+1.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
run  in  1  high while a DIV/MOD instruction occupies execute
u  in  1  1 = signed dividend (floor semantics), 0 = unsigned
stall  out  1  high while result not yet available
x  in  W  dividend, sampled at load cycle only
y  in  W  divisor, always unsigned magnitude, sampled at load cycle only
quot  out  W  quotient
rem  out  W  remainder

Behaviour:
- State: counter S (0..W+1), plus registers:
  - partial remainder R (W+1 bits)
  - quotient/dividend shift register Q
  - latched divisor D
  - latched flags: neg (u & x[W-1]) and zero (y==0).
- Reset: when rst==0 at an edge, S<=0, R,Q,D,neg,zero<=0. quot and rem read 0 after reset until the next completed operation.
- Counter rule: S <= run ? min(S+1, W+1) : 0. S saturates at W+1 and never wraps.
- stall = run & (S != W+1), combinational.
- S==0 (load cycle, run high):
  - Q <= neg ? -x : x (two's-complement magnitude; x=0x80000000 gives magnitude 2^31).
  - D <= y, R <= 0, latch neg and zero.
- S=1..W (iterate cycles):
  - t = {R[W-1:0], Q[W-1]} - {1'b0, D}.
  - If t non-negative: R <= t, shift 1 into Q LSB.
  - Else: R <= {R[W-1:0], Q[W-1]}, shift 0 into Q LSB.
- S==W+1 (done): the magnitude quotient q' is in Q and the magnitude remainder r' is in R[W-1:0]. Outputs, combinational from registers:
  - zero: quot = all ones, rem = x as latched; a copy of x is kept for this case.
  - else if !neg: quot = q', rem = r'.
  - else if r'==0: quot = -q', rem = 0.
  - else: quot = -q' - 1, rem = D - r'.
- Results stay stable while S==W+1 and run stays high. They remain unchanged after run falls until the next load.
- Latency: stall is high for W+1 cycles after run rises (load + W iterations). It is low on cycle W+2; the CPU advances at that edge.
- run drops mid-operation: S<=0, partial state is discarded, and the next run high restarts from load. quot/rem are undefined until S==W+1 again.
- Reset mid-operation: reset wins over run, with identical effect to the reset rule above. The operation restarts only after rst returns to 1 with run high.
- Back-to-back ops: run must fall for at least one cycle (S returns to 0) between instructions, as in the execute stage today.
- Signed mode with y having MSB set: y is still treated as an unsigned magnitude. No error is flagged.

Decomposition:
- Shared package div_pkg holds:
  - localparams LOAD=0, DONE=W+1
  - the counter width $clog2(W+2)
  - the div-by-zero quotient constant (all ones).
- One natural sub-module, div_step: combinational trial subtract. Inputs: R, Q MSB, D. Outputs: next R, quotient bit.
- The top level holds the counter, registers, sign fix-up and output mux.

Test Plan:
- Unsigned, u=0, x=100, y=7, run held high → stall high for exactly 33 cycles, low on cycle 34; quot=14, rem=2.
- Signed floor, u=1, x=-7 (0xFFFFFFF9), y=2 → quot=0xFFFFFFFC (-4), rem=1. Also x=-6, y=2 → quot=0xFFFFFFFD, rem=0.
- Extreme, u=1, x=0x80000000:
  - y=1 → quot=0x80000000, rem=0.
  - y=3 → quot=0xD5555555, rem=1.
  - Same x with u=0, y=3 → quot=0x2AAAAAAA, rem=2.
- Divide by zero, y=0:
  - u=0, x=0x12345678 → quot=0xFFFFFFFF, rem=0x12345678.
  - u=1, x=-5 → quot=0xFFFFFFFF, rem=0xFFFFFFFB.
- Saturation: run held high 100 cycles → S stays at 33, stall stays low, quot/rem unchanged. Dropping run then raising it restarts with 33 stall cycles.
- Mid-op disruption:
  - rst=0 for one cycle at S=10 → next cycle S=0, quot=rem=0.
  - Separately, run dropped at S=20 then reasserted with x=9, y=4 → quot=2, rem=1 after a full 33 stall cycles.
